fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Decoupled, parametrised instruction-fetch unit replacing the single-cycle PC/mem fetch path.
//  Issues sequential PC requests to an instruction memory/cache over a valid/ready request channel.
//  Accepts in-order responses into a DEPTH-entry instruction queue.
//  Presents instructions to decode with valid/ready, so memory latency and decode stalls are absorbed.
//  Supports redirect (branch/jump) with flush and discard of in-flight responses.
// PARAMETERS
//  ADDR_WIDTH   64     PC / memory address width
//  INSTR_WIDTH  32     instruction width
//  DEPTH        4      instruction-queue entries = max in-flight requests; power of 2, >=2
//  RESET_PC     'h0    fetch and head PC after reset
// PORTS
//  i_clk            in   1            clock, rising edge
//  i_arst           in   1            asynchronous reset, active-low
//  i_redirect       in   1            redirect fetch (branch/jump taken)
//  i_redirect_pc    in   ADDR_WIDTH   redirect target; bits [1:0] ignored (treated as 0)
//  o_mem_req_valid  out  1            request valid
//  o_mem_req_addr   out  ADDR_WIDTH   request address (fetch PC)
//  i_mem_req_ready  in   1            memory accepts request
//  i_mem_rsp_valid  in   1            response valid; responses strictly in request order
//  i_mem_rsp_data   in   INSTR_WIDTH  response instruction
//  o_instr_valid    out  1            queue head valid
//  i_instr_ready    in   1            decode consumes head
//  o_instruction    out  INSTR_WIDTH  head instruction
//  o_pc             out  ADDR_WIDTH   PC of head instruction
//  o_pc_plus4       out  ADDR_WIDTH   o_pc + 4
// BEHAVIOUR
//  Reset (i_arst=0, async):
//   - fetch_pc=RESET_PC, o_pc=RESET_PC; queue count, outstanding and drop_cnt = 0.
//   - o_mem_req_valid=0, o_instr_valid=0.
//   - o_instruction=0, o_mem_req_addr=RESET_PC.
//  Credit: o_mem_req_valid = !i_redirect && (count + outstanding + drop_cnt < DEPTH); o_mem_req_addr = fetch_pc.
//   - Once valid, addr held stable until accepted; only i_redirect may retract it.
//  Req handshake (valid && ready): fetch_pc += 4 (mod 2^ADDR_WIDTH, wrap silently); outstanding++.
//  Response (no redirect, drop_cnt==0): data written to queue tail, outstanding--.
//   - Earliest o_instr_valid is the cycle after i_mem_rsp_valid (1-cycle min latency).
//   - i_mem_rsp_valid while outstanding+drop_cnt==0 is ignored (protocol error; assertion fires).
//  Pop (o_instr_valid && i_instr_ready): head advances; o_pc += 4.
//   - Simultaneous push and pop are legal at any occupancy.
//   - Credit rule guarantees no overflow; full queue only stalls requests.
//  o_instr_valid = count!=0; o_instruction/o_pc driven from registers (no comb path from i_instr_ready).
//  Redirect (cycle R, highest priority):
//   - Queue flushed (count=0); fetch_pc=o_pc=i_redirect_pc & ~3.
//   - Any response in R is discarded.
//   - drop_cnt += outstanding (minus 1 if a response arrived in R); outstanding=0.
//   - No request issued in R; first request to new PC in R+1 if credit allows.
//  Drop: response while drop_cnt!=0 -> discarded, drop_cnt--; never enters queue.
//  Back-to-back redirects: each flushes; drop_cnt accumulates; last target wins.
//  Counters sized $clog2(DEPTH)+1; invariant count+outstanding+drop_cnt <= DEPTH.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs o_perf_fetched[31:0] and o_perf_bubbles[31:0].
//   - o_perf_fetched: counts pops.
//   - o_perf_bubbles: counts cycles with i_instr_ready=1 && o_instr_valid=0.
//   - Both reset to 0, wrap at 2^32, unaffected by redirect.
//  FETCH_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset release, mem ready=1, rsp 1 cycle later, decode ready=1
//    -> req addrs 0,4,8,...; o_pc 0,4,8 with one instr per cycle after fill.
//  2 DEPTH=4, i_instr_ready=0, mem always ready
//    -> exactly 4 requests accepted, then o_mem_req_valid=0 until a pop frees one credit.
//  3 i_mem_req_ready=0 for 5 cycles -> o_mem_req_valid=1 with addr held constant; accepted on 6th.
//  4 Two requests outstanding, redirect to 0x1002 -> queue empty next cycle.
//    -> next req addr 0x1000; the 2 stale responses dropped; first o_pc=0x1000.
//  5 Redirect in same cycle as response and pop -> response dropped, no request in R, o_pc=target.
//  6 Assert i_arst=0 mid-stream with outstanding requests -> outputs at reset values immediately (async).
//    -> fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch unit: credit-limited sequential requests, in-order response queue,
// redirect with flush and stale-response discard. Define FETCH_PERF_EN for pop/bubble counters.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_rsp_data,
  output logic                   o_instr_valid,
  input  logic                   i_instr_ready,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            o_perf_fetched,
  output logic [31:0]            o_perf_bubbles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d, pc_q, pc_d, redirect_tgt;
  logic [CW-1:0]          count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
  logic [INSTR_WIDTH-1:0] mem_d [DEPTH];
  logic [SW-1:0]          used;
  logic                   credit, req_fire, inflight_nz, rsp_take, push, pop;

  // Handshakes: a transfer happens on a rising edge where valid && ready; once the request
  // valid is raised its address stays fixed until accepted, and only a redirect withdraws it.
  assign used        = SW'(count_q) + SW'(out_q) + SW'(drop_q);
  assign credit      = used < SW'(DEPTH);
  assign redirect_tgt = i_redirect_pc & ~ADDR_WIDTH'(3);
  // Gated by the reset pin so the request channel is quiet while reset is held.
  assign o_mem_req_valid = i_arst && !i_redirect && credit;
  assign o_mem_req_addr  = fetch_pc_q;
  assign req_fire        = o_mem_req_valid && i_mem_req_ready;
  assign inflight_nz     = (out_q != '0) || (drop_q != '0);
  assign rsp_take        = i_mem_rsp_valid && inflight_nz;
  assign push            = rsp_take && (drop_q == '0) && !i_redirect;
  assign pop             = (count_q != '0) && i_instr_ready;

  assign o_instr_valid = count_q != '0;
  assign o_instruction = mem_q[head_q];
  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_q + ADDR_WIDTH'(4);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    mem_d      = mem_q;
    if (i_redirect) begin
      fetch_pc_d = redirect_tgt;
      pc_d       = redirect_tgt;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      out_d      = '0;
      // A response in the redirect cycle is retired from whichever pool it belongs to.
      drop_d     = drop_q + out_q - CW'(rsp_take);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      if (rsp_take && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        mem_d[tail_q] = i_mem_rsp_data;
        tail_d        = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
        pc_d   = pc_q + ADDR_WIDTH'(4);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      out_d   = out_q + CW'(req_fire) - CW'(push);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      mem_q      <= mem_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_bubbles_d = perf_bubbles_q + 32'(i_instr_ready && (count_q == '0));
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign o_perf_fetched = perf_fetched_q;
  assign o_perf_bubbles = perf_bubbles_q;
`else
  // Without FETCH_PERF_EN no counters are built.
`endif

  rsp_without_request: assert property (@(posedge i_clk) disable iff (!i_arst)
    i_mem_rsp_valid |-> inflight_nz);
  credit_bound: assert property (@(posedge i_clk) disable iff (!i_arst)
    used <= SW'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect/reset sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;
  localparam int          AW       = 64;
  localparam int          IW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic          i_clk, i_arst, i_redirect, i_mem_req_ready, i_mem_rsp_valid, i_instr_ready;
  logic [AW-1:0] i_redirect_pc, o_mem_req_addr, o_pc, o_pc_plus4;
  logic [IW-1:0] i_mem_rsp_data, o_instruction;
  logic          o_mem_req_valid, o_instr_valid;
`ifdef FETCH_PERF_EN
  logic [31:0]   o_perf_fetched, o_perf_bubbles;
`endif

  fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_req_ready(i_mem_req_ready), .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data(i_mem_rsp_data), .o_instr_valid(o_instr_valid),
    .i_instr_ready(i_instr_ready), .o_instruction(o_instruction), .o_pc(o_pc),
    .o_pc_plus4(o_pc_plus4)
`ifdef FETCH_PERF_EN
    , .o_perf_fetched(o_perf_fetched), .o_perf_bubbles(o_perf_bubbles)
`endif
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        iq[$];        // instructions waiting for decode
  logic [63:0] mem_pend[$];  // accepted requests the memory still owes a response for
  logic [63:0] m_fetch, m_head;
  int          m_out, m_drop;

  function automatic logic [31:0] f_data(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    m_fetch = RESET_PC;
    m_head  = RESET_PC;
    m_out   = 0;
    m_drop  = 0;
    iq.delete();
    mem_pend.delete();
  endtask

  task automatic drive_idle();
    i_redirect      = 1'b0;
    i_redirect_pc   = '0;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data  = '0;
    i_instr_ready   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    drive_idle();
    i_arst = 1'b0;
    repeat (2) @(negedge i_clk);
    i_arst = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, advance the model.
  task automatic step(input bit rdy, input bit rsp, input bit ir, input bit redir,
                      input logic [63:0] rpc);
    bit          do_rsp, exp_rv, fire;
    logic [63:0] a, exp_pc;
    @(negedge i_clk);
    do_rsp = rsp && (mem_pend.size() != 0);
    a      = do_rsp ? mem_pend.pop_front() : 64'h0;
    i_mem_req_ready = rdy;
    i_mem_rsp_valid = do_rsp;
    i_mem_rsp_data  = do_rsp ? f_data(a) : $urandom;
    i_instr_ready   = ir;
    i_redirect      = redir;
    i_redirect_pc   = rpc;
    #1;
    exp_rv = !redir && ((iq.size() + m_out + m_drop) < DEPTH);
    exp_pc = (iq.size() != 0) ? iq[0].addr : m_head;
    check("req_valid", 64'(o_mem_req_valid), 64'(exp_rv));
    check("req_addr", o_mem_req_addr, m_fetch);
    check("instr_valid", 64'(o_instr_valid), 64'(iq.size() != 0));
    if (iq.size() != 0) check("instruction", 64'(o_instruction), 64'(iq[0].data));
    check("pc", o_pc, exp_pc);
    check("pc_plus4", o_pc_plus4, exp_pc + 64'd4);
    fire = exp_rv && rdy;
    if (redir) begin
      iq.delete();
      m_fetch = rpc & ~64'h3;
      m_head  = rpc & ~64'h3;
      m_drop  = m_drop + m_out - (do_rsp ? 1 : 0);
      m_out   = 0;
    end else begin
      if (ir && iq.size() != 0) begin
        void'(iq.pop_front());
        m_head = m_head + 64'd4;
      end
      if (do_rsp) begin
        if (m_drop > 0) m_drop--;
        else begin
          iq.push_back('{addr: a, data: f_data(a)});
          m_out--;
        end
      end
      if (fire) begin
        mem_pend.push_back(m_fetch);
        m_fetch = m_fetch + 64'd4;
        m_out++;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rdy;
    bit          rsp;
    logic [31:0] data;
    bit          ir;
    bit          exp_rv;
    logic [63:0] exp_addr;
    bit          exp_iv;
    bit          chk_instr;
    logic [31:0] exp_instr;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t tv[13];

  initial begin
    tv[0]  = '{1, 0, 32'h0,         0, 1, 64'h00, 0, 1, 32'h0,         64'h00};
    tv[1]  = '{1, 1, 32'hC0DE_0000, 0, 1, 64'h04, 0, 1, 32'h0,         64'h00};
    tv[2]  = '{1, 1, 32'hC0DE_0001, 0, 1, 64'h08, 1, 1, 32'hC0DE_0000, 64'h00};
    tv[3]  = '{1, 1, 32'hC0DE_0002, 0, 1, 64'h0C, 1, 1, 32'hC0DE_0000, 64'h00};
    tv[4]  = '{1, 1, 32'hC0DE_0003, 0, 0, 64'h10, 1, 1, 32'hC0DE_0000, 64'h00};
    tv[5]  = '{1, 0, 32'h0,         0, 0, 64'h10, 1, 1, 32'hC0DE_0000, 64'h00};
    tv[6]  = '{1, 0, 32'h0,         1, 0, 64'h10, 1, 1, 32'hC0DE_0000, 64'h00};
    tv[7]  = '{1, 0, 32'h0,         0, 1, 64'h10, 1, 1, 32'hC0DE_0001, 64'h04};
    tv[8]  = '{0, 1, 32'hC0DE_0004, 1, 0, 64'h14, 1, 1, 32'hC0DE_0001, 64'h04};
    tv[9]  = '{1, 0, 32'h0,         1, 1, 64'h14, 1, 1, 32'hC0DE_0002, 64'h08};
    tv[10] = '{1, 0, 32'h0,         1, 1, 64'h18, 1, 1, 32'hC0DE_0003, 64'h0C};
    tv[11] = '{0, 0, 32'h0,         1, 1, 64'h1C, 1, 1, 32'hC0DE_0004, 64'h10};
    tv[12] = '{0, 0, 32'h0,         1, 1, 64'h1C, 0, 0, 32'h0,         64'h14};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [63:0] tgt;
    bit          rdy, rsp, ir, redir;
    i_arst = 1'b1;
    drive_idle();
    #1 i_arst = 1'b0;

    // Table: fill with decode stalled, credit exhaustion, then drain.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge i_clk);
      i_mem_req_ready = tv[i].rdy;
      i_mem_rsp_valid = tv[i].rsp;
      i_mem_rsp_data  = tv[i].data;
      i_instr_ready   = tv[i].ir;
      i_redirect      = 1'b0;
      #1;
      check($sformatf("tv%0d_req_valid", i), 64'(o_mem_req_valid), 64'(tv[i].exp_rv));
      check($sformatf("tv%0d_req_addr", i), o_mem_req_addr, tv[i].exp_addr);
      check($sformatf("tv%0d_instr_valid", i), 64'(o_instr_valid), 64'(tv[i].exp_iv));
      if (tv[i].chk_instr)
        check($sformatf("tv%0d_instruction", i), 64'(o_instruction), 64'(tv[i].exp_instr));
      check($sformatf("tv%0d_pc", i), o_pc, tv[i].exp_pc);
    end

    // Memory back-pressure: address held for 5 cycles, accepted on the 6th.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 64'h0);
      check("hold_valid", 64'(o_mem_req_valid), 64'd1);
      check("hold_addr", o_mem_req_addr, 64'h0);
    end
    step(1, 0, 0, 0, 64'h0);
    step(0, 0, 0, 0, 64'h0);
    check("hold_next_addr", o_mem_req_addr, 64'h4);

    // Redirect with two requests in flight; stale responses must be dropped.
    do_reset();
    step(1, 0, 0, 0, 64'h0);
    step(1, 0, 0, 0, 64'h0);
    step(0, 0, 0, 1, 64'h1002);
    check("redir_no_req", 64'(o_mem_req_valid), 64'd0);
    step(0, 0, 0, 0, 64'h0);
    check("redir_empty", 64'(o_instr_valid), 64'd0);
    check("redir_pc", o_pc, 64'h1000);
    check("redir_addr", o_mem_req_addr, 64'h1000);
    check("redir_req_valid", 64'(o_mem_req_valid), 64'd1);
    step(1, 1, 0, 0, 64'h0);
    step(0, 1, 0, 0, 64'h0);
    check("redir_stale_dropped", 64'(o_instr_valid), 64'd0);
    step(0, 1, 0, 0, 64'h0);
    step(0, 0, 0, 0, 64'h0);
    check("redir_first_valid", 64'(o_instr_valid), 64'd1);
    check("redir_first_pc", o_pc, 64'h1000);
    check("redir_first_instr", 64'(o_instruction), 64'(f_data(64'h1000)));

    // Redirect in the same cycle as a response and a pop.
    do_reset();
    step(1, 0, 0, 0, 64'h0);
    step(1, 1, 0, 0, 64'h0);
    step(1, 1, 1, 1, 64'h2000);
    check("same_cycle_no_req", 64'(o_mem_req_valid), 64'd0);
    step(0, 0, 0, 0, 64'h0);
    check("same_cycle_empty", 64'(o_instr_valid), 64'd0);
    check("same_cycle_pc", o_pc, 64'h2000);
    check("same_cycle_req_valid", 64'(o_mem_req_valid), 64'd1);
    step(1, 0, 0, 0, 64'h0);
    step(0, 1, 0, 0, 64'h0);
    step(0, 0, 1, 0, 64'h0);
    check("same_cycle_valid", 64'(o_instr_valid), 64'd1);
    check("same_cycle_instr", 64'(o_instruction), 64'(f_data(64'h2000)));

    // Fetch PC wraps at the top of the address space; low target bits are ignored.
    step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    step(1, 0, 0, 0, 64'h0);
    check("wrap_top_addr", o_mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 0, 64'h0);
    check("wrap_zero_addr", o_mem_req_addr, 64'h0);

    // Randomized traffic with an asynchronous reset part-way through.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        @(negedge i_clk);
        #2;
        i_arst = 1'b0;
        drive_idle();
        #1;
        check("async_req_valid", 64'(o_mem_req_valid), 64'd0);
        check("async_instr_valid", 64'(o_instr_valid), 64'd0);
        check("async_pc", o_pc, RESET_PC);
        check("async_addr", o_mem_req_addr, RESET_PC);
        check("async_instr", 64'(o_instruction), 64'd0);
        repeat (2) @(negedge i_clk);
        i_arst = 1'b1;
        model_reset();
        step(1, 0, 0, 0, 64'h0);
        check("restart_addr", o_mem_req_addr, RESET_PC);
      end
      rdy   = $urandom_range(0, 3) != 0;
      rsp   = $urandom_range(0, 9) < 7;
      ir    = $urandom_range(0, 2) != 0;
      redir = $urandom_range(0, 15) == 0;
      tgt   = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)}
                                          : {32'h0, 32'($urandom)};
      step(rdy, rsp, ir, redir, tgt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
